tea_decipher: RTL and testbench

Multi-cycle TEA block decipher. It is the inverse of the team's TEA cipher block: it takes a 64-bit ciphertext (two words) and a 128-bit key, and recovers the plaintext. Each Feistel round is run over several clock cycles through a small FSM. It sits behind the cipher in the encrypt/decrypt loopback datapath and uses the same level-sensitive iStart/oDone handshake.

---
 rtl/tea_pkg.sv | 29 ++
 rtl/tea_round_term.sv | 19 +
 rtl/tea_decipher.sv | 157 +++++++++++++++
 tb/tb_tea_decipher.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/tea_pkg.sv
// Shared TEA definitions: key-schedule constant, decipher FSM encoding and the
// initial sum helper used to start deciphering from the last round's sum.
package tea_pkg;

  localparam logic [31:0] TEA_DELTA = 32'h9e3779b9;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CALC_V1 = 3'd1;
  localparam logic [2:0] ST_SUB_V1  = 3'd2;
  localparam logic [2:0] ST_CALC_V0 = 3'd3;
  localparam logic [2:0] ST_SUB_V0  = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    CALC_V1 = ST_CALC_V1,
    SUB_V1  = ST_SUB_V1,
    CALC_V0 = ST_CALC_V0,
    SUB_V0  = ST_SUB_V0,
    DONE    = ST_DONE
  } tea_state_e;

  // Sum after 'rounds' encryption rounds, modulo 2^32.
  function automatic logic [31:0] tea_sum_init(input int unsigned rounds,
                                               input logic [31:0] delta = TEA_DELTA);
    return delta * 32'(rounds);
  endfunction

endpackage

// File: rtl/tea_round_term.sv
// Combinational TEA round terms (x<<4)+ka, x+s and (x>>5)+kb; the Feistel mix
// is their XOR. Shared between the cipher and decipher datapaths.
module tea_round_term #(
  parameter int WORD_SIZE = 32
) (
  input  logic [WORD_SIZE-1:0] x,
  input  logic [WORD_SIZE-1:0] s,
  input  logic [WORD_SIZE-1:0] ka,
  input  logic [WORD_SIZE-1:0] kb,
  output logic [WORD_SIZE-1:0] term_a,
  output logic [WORD_SIZE-1:0] term_b,
  output logic [WORD_SIZE-1:0] term_c
);

  assign term_a = (x << 4) + ka;
  assign term_b = x + s;
  assign term_c = (x >> 5) + kb;

endmodule

// File: rtl/tea_decipher.sv
// Multi-cycle TEA block decipher, four cycles per Feistel round, level iStart/oDone
// handshake. Define TEA_DECIPHER_KEY_LATCH_EN to capture the key at start.
//
// state   | meaning
// IDLE    | waiting for iStart; loads ciphertext, sum and count
// CALC_V1 | register the three terms of the v1 mix from oP0
// SUB_V1  | oP1 -= mix
// CALC_V0 | register the three terms of the v0 mix from oP1
// SUB_V0  | oP0 -= mix, sum -= DELTA, advance round count
// DONE    | result valid, wait for iStart to drop
module tea_decipher
  import tea_pkg::*;
#(
  parameter int          WORD_SIZE    = 32,
  parameter logic [31:0] DELTA        = TEA_DELTA,
  parameter int          ROUND_NUMBER = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iStart,
  input  logic [WORD_SIZE-1:0] iC0,
  input  logic [WORD_SIZE-1:0] iC1,
  input  logic [WORD_SIZE-1:0] iK0,
  input  logic [WORD_SIZE-1:0] iK1,
  input  logic [WORD_SIZE-1:0] iK2,
  input  logic [WORD_SIZE-1:0] iK3,
  output logic [WORD_SIZE-1:0] oP0,
  output logic [WORD_SIZE-1:0] oP1,
  output logic                 oDone
);

  localparam int              CW       = (ROUND_NUMBER > 1) ? $clog2(ROUND_NUMBER) : 1;
  localparam logic [CW-1:0]   LAST     = CW'(ROUND_NUMBER - 1);
  localparam logic [31:0]     SUM_INIT = tea_sum_init(ROUND_NUMBER, DELTA);

  tea_state_e state, state_nxt;

  logic [31:0]          sum;
  logic [CW-1:0]        count;
  logic [WORD_SIZE-1:0] ra, rb, rc;
  logic [WORD_SIZE-1:0] k0, k1, k2, k3;
  logic [WORD_SIZE-1:0] term_x, term_ka, term_kb;
  logic [WORD_SIZE-1:0] term_a, term_b, term_c;
  logic [WORD_SIZE-1:0] mix;
  logic                 load;

  assign load = (state == IDLE) && iStart;

`ifdef TEA_DECIPHER_KEY_LATCH_EN
  logic [WORD_SIZE-1:0] key0, key1, key2, key3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key0 <= '0;
      key1 <= '0;
      key2 <= '0;
      key3 <= '0;
    end else if (load) begin
      key0 <= iK0;
      key1 <= iK1;
      key2 <= iK2;
      key3 <= iK3;
    end
  end

  assign k0 = key0;
  assign k1 = key1;
  assign k2 = key2;
  assign k3 = key3;
`else
  assign k0 = iK0;
  assign k1 = iK1;
  assign k2 = iK2;
  assign k3 = iK3;
`endif

  // CALC_V0 works on oP1 with K0/K1; every other state uses the v1 operands.
  assign term_x  = (state == CALC_V0) ? oP1 : oP0;
  assign term_ka = (state == CALC_V0) ? k0  : k2;
  assign term_kb = (state == CALC_V0) ? k1  : k3;

  tea_round_term #(
    .WORD_SIZE (WORD_SIZE)
  ) u_round_term (
    .x      (term_x),
    .s      (WORD_SIZE'(sum)),
    .ka     (term_ka),
    .kb     (term_kb),
    .term_a (term_a),
    .term_b (term_b),
    .term_c (term_c)
  );

  assign mix = ra ^ rb ^ rc;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (iStart) state_nxt = CALC_V1;
      CALC_V1: state_nxt = iStart ? SUB_V1  : IDLE;
      SUB_V1:  state_nxt = iStart ? CALC_V0 : IDLE;
      CALC_V0: state_nxt = iStart ? SUB_V0  : IDLE;
      SUB_V0: begin
        if (!iStart)            state_nxt = IDLE;
        else if (count == LAST) state_nxt = DONE;
        else                    state_nxt = CALC_V1;
      end
      DONE:    if (!iStart) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      oDone <= 1'b0;
    end else begin
      state <= state_nxt;
      oDone <= (state_nxt == DONE);
    end
  end

  // Datapath updates are gated by iStart so an abort edge leaves partial values intact.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oP0   <= '0;
      oP1   <= '0;
      sum   <= '0;
      count <= '0;
      ra    <= '0;
      rb    <= '0;
      rc    <= '0;
    end else if (iStart) begin
      case (state)
        IDLE: begin
          oP0   <= iC0;
          oP1   <= iC1;
          sum   <= SUM_INIT;
          count <= '0;
        end
        CALC_V1, CALC_V0: begin
          ra <= term_a;
          rb <= term_b;
          rc <= term_c;
        end
        SUB_V1: oP1 <= oP1 - mix;
        SUB_V0: begin
          oP0   <= oP0 - mix;
          sum   <= sum - DELTA;
          count <= count + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tea_decipher.sv
// Directed bench for tea_decipher: known vector, encrypt/decrypt loopback,
// abort, async reset, handshake hold and (when enabled) key latching.
module tb_tea_decipher;

  localparam int EXP_LAT = 129;  // edges counted from the load edge (edge 1) to oDone

  logic        clk = 1'b0;
  logic        rst;
  logic        iStart;
  logic [31:0] iC0, iC1, iK0, iK1, iK2, iK3;
  logic [31:0] oP0, oP1;
  logic        oDone;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  tea_decipher dut (
    .clk    (clk),
    .rst    (rst),
    .iStart (iStart),
    .iC0    (iC0),
    .iC1    (iC1),
    .iK0    (iK0),
    .iK1    (iK1),
    .iK2    (iK2),
    .iK3    (iK3),
    .oP0    (oP0),
    .oP1    (oP1),
    .oDone  (oDone)
  );

  function automatic void tea_encrypt(input logic [31:0] v0i, v1i, k0, k1, k2, k3,
                                      output logic [31:0] c0, output logic [31:0] c1);
    logic [31:0] v0, v1, s;
    v0 = v0i;
    v1 = v1i;
    s  = 32'h0;
    for (int i = 0; i < 32; i++) begin
      s  = s + 32'h9e3779b9;
      v0 = v0 + (((v1 << 4) + k0) ^ (v1 + s) ^ ((v1 >> 5) + k1));
      v1 = v1 + (((v0 << 4) + k2) ^ (v0 + s) ^ ((v0 >> 5) + k3));
    end
    c0 = v0;
    c1 = v1;
  endfunction

  task automatic run_op(input logic [31:0] c0, c1, k0, k1, k2, k3, output int lat);
    @(negedge clk);
    iC0 = c0; iC1 = c1;
    iK0 = k0; iK1 = k1; iK2 = k2; iK3 = k3;
    iStart = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (oDone !== 1'b1 && lat < 300);
  endtask

  task automatic release_start();
    @(negedge clk);
    iStart = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; iStart = 1'b0;
    iC0 = '0; iC1 = '0; iK0 = '0; iK1 = '0; iK2 = '0; iK3 = '0;
    #3;
    total_cnt++;
    if (oP0 !== 32'h0) $display("FAIL reset_p0 got=%h exp=0", oP0); else pass_cnt++;
    total_cnt++;
    if (oP1 !== 32'h0) $display("FAIL reset_p1 got=%h exp=0", oP1); else pass_cnt++;
    total_cnt++;
    if (oDone !== 1'b0) $display("FAIL reset_done got=%b exp=0", oDone); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_known_vector();
    int lat;
    run_op(32'h41EA3A0A, 32'h94BAA940, 32'h0, 32'h0, 32'h0, 32'h0, lat);
    total_cnt++;
    if (lat != EXP_LAT) $display("FAIL known_latency got=%0d exp=%0d", lat, EXP_LAT); else pass_cnt++;
    total_cnt++;
    if (oP0 !== 32'h0) $display("FAIL known_p0 got=%h exp=0", oP0); else pass_cnt++;
    total_cnt++;
    if (oP1 !== 32'h0) $display("FAIL known_p1 got=%h exp=0", oP1); else pass_cnt++;
    release_start();
  endtask

  task automatic test_loopback();
    logic [31:0] v0, v1, k0, k1, k2, k3, c0, c1;
    int lat;
    for (int n = 0; n < 100; n++) begin
      v0 = $urandom; v1 = $urandom;
      k0 = $urandom; k1 = $urandom; k2 = $urandom; k3 = $urandom;
      tea_encrypt(v0, v1, k0, k1, k2, k3, c0, c1);
      run_op(c0, c1, k0, k1, k2, k3, lat);
      total_cnt++;
      if (oP0 !== v0 || oP1 !== v1)
        $display("FAIL loopback_%0d got=%h_%h exp=%h_%h", n, oP0, oP1, v0, v1);
      else pass_cnt++;
      total_cnt++;
      if (lat != EXP_LAT) $display("FAIL loopback_lat_%0d got=%0d exp=%0d", n, lat, EXP_LAT);
      else pass_cnt++;
      release_start();
    end
  endtask

  task automatic test_abort();
    logic [31:0] c0, c1;
    int lat;
    @(negedge clk);
    iC0 = 32'h01234567; iC1 = 32'h89abcdef;
    iK0 = 32'h11111111; iK1 = 32'h22222222; iK2 = 32'h33333333; iK3 = 32'h44444444;
    iStart = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    total_cnt++;
    if (oDone !== 1'b0) $display("FAIL abort_busy_done got=%b exp=0", oDone); else pass_cnt++;
    @(negedge clk);
    iStart = 1'b0;
    @(posedge clk);
    #1;
    total_cnt++;
    if (oDone !== 1'b0) $display("FAIL abort_done got=%b exp=0", oDone); else pass_cnt++;
    total_cnt++;
    if (dut.state !== 3'd0) $display("FAIL abort_state got=%0d exp=0", dut.state); else pass_cnt++;
    tea_encrypt(32'hdeadbeef, 32'hcafef00d, 32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504,
                32'h03020100, c0, c1);
    run_op(c0, c1, 32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100, lat);
    total_cnt++;
    if (lat != EXP_LAT || oP0 !== 32'hdeadbeef || oP1 !== 32'hcafef00d)
      $display("FAIL abort_restart got=%h_%h lat=%0d exp=deadbeef_cafef00d lat=%0d",
               oP0, oP1, lat, EXP_LAT);
    else pass_cnt++;
    release_start();
  endtask

  task automatic test_async_reset();
    logic [31:0] c0, c1;
    int lat;
    @(negedge clk);
    iC0 = 32'h55aa55aa; iC1 = 32'h12345678;
    iK0 = 32'h1; iK1 = 32'h2; iK2 = 32'h3; iK3 = 32'h4;
    iStart = 1'b1;
    repeat (37) @(posedge clk);
    #4;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (oP0 !== 32'h0 || oP1 !== 32'h0 || oDone !== 1'b0)
      $display("FAIL async_reset got=%h_%h done=%b exp=0_0 done=0", oP0, oP1, oDone);
    else pass_cnt++;
    @(negedge clk);
    iStart = 1'b0;
    rst = 1'b1;
    tea_encrypt(32'h0badf00d, 32'h600dcafe, 32'h9, 32'h8, 32'h7, 32'h6, c0, c1);
    run_op(c0, c1, 32'h9, 32'h8, 32'h7, 32'h6, lat);
    total_cnt++;
    if (lat != EXP_LAT || oP0 !== 32'h0badf00d || oP1 !== 32'h600dcafe)
      $display("FAIL reset_recovery got=%h_%h lat=%0d exp=0badf00d_600dcafe lat=%0d",
               oP0, oP1, lat, EXP_LAT);
    else pass_cnt++;
    release_start();
  endtask

  task automatic test_handshake();
    logic [31:0] c0, c1;
    int lat;
    int bad;
    tea_encrypt(32'hfeedface, 32'h00c0ffee, 32'ha5a5a5a5, 32'h5a5a5a5a, 32'hffffffff,
                32'h80000000, c0, c1);
    run_op(c0, c1, 32'ha5a5a5a5, 32'h5a5a5a5a, 32'hffffffff, 32'h80000000, lat);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (oDone !== 1'b1 || oP0 !== 32'hfeedface || oP1 !== 32'h00c0ffee) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL hold_high bad_cycles=%0d exp=0", bad); else pass_cnt++;
    release_start();
    total_cnt++;
    if (oDone !== 1'b0) $display("FAIL drop_done got=%b exp=0", oDone); else pass_cnt++;
    total_cnt++;
    if (oP0 !== 32'hfeedface || oP1 !== 32'h00c0ffee)
      $display("FAIL drop_retain got=%h_%h exp=feedface_00c0ffee", oP0, oP1);
    else pass_cnt++;
  endtask

`ifdef TEA_DECIPHER_KEY_LATCH_EN
  task automatic test_key_latch();
    logic [31:0] c0, c1;
    int lat;
    tea_encrypt(32'h13579bdf, 32'h2468ace0, 32'hcafe0001, 32'hcafe0002, 32'hcafe0003,
                32'hcafe0004, c0, c1);
    @(negedge clk);
    iC0 = c0; iC1 = c1;
    iK0 = 32'hcafe0001; iK1 = 32'hcafe0002; iK2 = 32'hcafe0003; iK3 = 32'hcafe0004;
    iStart = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
      iK0 = $urandom; iK1 = $urandom; iK2 = $urandom; iK3 = $urandom;
    end while (oDone !== 1'b1 && lat < 300);
    total_cnt++;
    if (lat != EXP_LAT || oP0 !== 32'h13579bdf || oP1 !== 32'h2468ace0)
      $display("FAIL key_latch got=%h_%h lat=%0d exp=13579bdf_2468ace0 lat=%0d",
               oP0, oP1, lat, EXP_LAT);
    else pass_cnt++;
    release_start();
  endtask
`endif

  initial begin
    test_reset();
    test_known_vector();
    test_loopback();
    test_abort();
    test_async_reset();
    test_handshake();
`ifdef TEA_DECIPHER_KEY_LATCH_EN
    test_key_latch();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
